// File: rtl/branch_resolve_unit_pkg.sv
// Shared encodings, BHT counter constants and the resolve datapath payload
// for the EX-stage branch resolve unit.
package branch_resolve_unit_pkg;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  localparam logic [1:0] BHT_SNT  = 2'b00;
  localparam logic [1:0] BHT_WNT  = 2'b01;
  localparam logic [1:0] BHT_WT   = 2'b10;
  localparam logic [1:0] BHT_ST   = 2'b11;
  localparam logic [1:0] BHT_INIT = BHT_WNT;

  typedef struct packed {
    logic        taken;
    logic        mispred;
    logic [31:0] fix_pc;
  } resolve_t;

  // Saturating 2-bit counter step toward the observed outcome.
  function automatic logic [1:0] bht_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken && cnt != BHT_ST)
      nxt = cnt + 2'd1;
    else if (!taken && cnt != BHT_SNT)
      nxt = cnt - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_bht.sv
// Branch history table: array of 2-bit saturating counters with one
// combinational read port (IF) and one edge-written update port (EX).
module branch_resolve_unit_bht
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken_c,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  logic [1:0] cnt_q [ENTRIES];

  // Writes land at the edge, so a same-cycle read sees the old counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(ENTRIES); i++)
        cnt_q[i] <= BHT_INIT;
    end else if (upd_en) begin
      cnt_q[upd_idx] <= bht_next(cnt_q[upd_idx], upd_taken);
    end
  end

  assign rd_taken_c = cnt_q[rd_idx][1];

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: outcome/target check against the IF prediction,
// registered redirect, multi-cycle wrong-path flush, perf counters and the BHT.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned FLUSH_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc,
  output logic        if_pred_taken,
  input  logic        ex_valid,
  input  logic        ex_stall,
  input  logic        ex_is_branch,
  input  logic        ex_is_jal,
  input  logic        ex_is_jalr,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [31:0] ex_rs1,
  input  logic        branch_result,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic [31:0] perf_branches,
  output logic [31:0] perf_mispred
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);
  localparam int unsigned CNT_W = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_DEPTH - 1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             redirect_valid_q, redirect_valid_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic             flush_q, flush_d;
  logic [31:0]      perf_branches_q, perf_branches_d;
  logic [31:0]      perf_mispred_q, perf_mispred_d;

  logic [31:0]      target;
  resolve_t         res;
  logic             resolve;
  logic             bht_en;
  logic             unused_if_pc;

  assign unused_if_pc = ^{if_pc[31:IDX_W+2], if_pc[1:0]};

  // Outcome, target and mispredict; JALR clears bit 0 of its target.
  always_comb begin
    target = ex_is_jalr ? ((ex_rs1 + ex_imm) & ~32'h1) : (ex_pc + ex_imm);
    res.taken   = ex_is_jal | ex_is_jalr | (ex_is_branch & branch_result);
    res.mispred = (res.taken != ex_pred_taken)
                | (res.taken & ex_pred_taken & (target != ex_pred_target));
    res.fix_pc  = res.taken ? target : (ex_pc + 32'd4);
  end

  assign resolve = ex_valid & ~ex_stall & (state_q == ST_RUN)
                 & (ex_is_branch | ex_is_jal | ex_is_jalr);
  assign bht_en  = resolve & ex_is_branch & ~ex_is_jal & ~ex_is_jalr;

  branch_resolve_unit_bht #(
    .ENTRIES (BHT_ENTRIES),
    .IDX_W   (IDX_W)
  ) u_bht (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_idx     (if_pc[IDX_W+1:2]),
    .rd_taken_c (if_pred_taken),
    .upd_en     (bht_en),
    .upd_idx    (ex_pc[IDX_W+1:2]),
    .upd_taken  (res.taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_RUN;
      flush_cnt_q      <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
      perf_branches_q  <= '0;
      perf_mispred_q   <= '0;
    end else begin
      state_q          <= state_d;
      flush_cnt_q      <= flush_cnt_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
      perf_branches_q  <= perf_branches_d;
      perf_mispred_q   <= perf_mispred_d;
    end
  end

  // Redirect is a single-cycle pulse; FLUSH ignores EX and counts down.
  always_comb begin
    state_d          = state_q;
    flush_cnt_d      = flush_cnt_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    flush_d          = flush_q;
    perf_branches_d  = perf_branches_q;
    perf_mispred_d   = perf_mispred_q;
    case (state_q)
      ST_RUN: begin
        if (resolve) begin
          perf_branches_d = perf_branches_q + 32'd1;
          if (res.mispred) begin
            perf_mispred_d   = perf_mispred_q + 32'd1;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = res.fix_pc;
            flush_d          = 1'b1;
            flush_cnt_d      = CNT_LOAD;
            state_d          = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == '0) begin
          flush_d = 1'b0;
          state_d = ST_RUN;
        end else begin
          flush_cnt_d = flush_cnt_q - 1'b1;
        end
      end
      default: begin
        flush_d = 1'b0;
        state_d = ST_RUN;
      end
    endcase
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush          = flush_q;
  assign perf_branches  = perf_branches_q;
  assign perf_mispred   = perf_mispred_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: vector table plus hand-built
// sequences for BHT saturation, flush window, stall and async reset.
module tb_branch_resolve_unit;

  localparam int unsigned FLUSH_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        ex_valid, ex_stall, ex_is_branch, ex_is_jal, ex_is_jalr;
  logic [31:0] ex_pc, ex_imm, ex_rs1;
  logic        branch_result, ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [31:0] perf_branches, perf_mispred;

  always #5 clk = ~clk;

  branch_resolve_unit #(
    .BHT_ENTRIES (64),
    .FLUSH_DEPTH (FLUSH_DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_pc          (if_pc),
    .if_pred_taken  (if_pred_taken),
    .ex_valid       (ex_valid),
    .ex_stall       (ex_stall),
    .ex_is_branch   (ex_is_branch),
    .ex_is_jal      (ex_is_jal),
    .ex_is_jalr     (ex_is_jalr),
    .ex_pc          (ex_pc),
    .ex_imm         (ex_imm),
    .ex_rs1         (ex_rs1),
    .branch_result  (branch_result),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .perf_branches  (perf_branches),
    .perf_mispred   (perf_mispred)
  );

  typedef struct packed {
    logic        br, jal, jalr;
    logic [31:0] pc, imm, rs1;
    logic        res, pt;
    logic [31:0] ptgt;
    logic        exp_rv;
    logic [31:0] exp_pc;
  } vec_t;

  typedef struct packed {
    logic        rv;
    logic [31:0] pc;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_br  = 0;
  int   n_mp  = 0;

  function automatic vec_t mk(input logic br, input logic jal, input logic jalr,
                              input logic [31:0] pc, input logic [31:0] imm,
                              input logic [31:0] rs1, input logic res, input logic pt,
                              input logic [31:0] ptgt, input logic erv,
                              input logic [31:0] epc);
    vec_t v;
    v.br = br; v.jal = jal; v.jalr = jalr; v.pc = pc; v.imm = imm; v.rs1 = rs1;
    v.res = res; v.pt = pt; v.ptgt = ptgt; v.exp_rv = erv; v.exp_pc = epc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid = 1'b0; ex_stall = 1'b0;
    ex_is_branch = 1'b0; ex_is_jal = 1'b0; ex_is_jalr = 1'b0;
  endtask

  task automatic set_inputs(input vec_t v);
    ex_valid = 1'b1; ex_is_branch = v.br; ex_is_jal = v.jal; ex_is_jalr = v.jalr;
    ex_pc = v.pc; ex_imm = v.imm; ex_rs1 = v.rs1; branch_result = v.res;
    ex_pred_taken = v.pt; ex_pred_target = v.ptgt;
  endtask

  // Present a resolving instruction and queue the result it must produce.
  task automatic drive(input vec_t v);
    exp_t e;
    set_inputs(v);
    ex_stall = 1'b0;
    e.rv = v.exp_rv;
    e.pc = v.exp_pc;
    sb_q.push_back(e);
    n_br++;
    if (v.exp_rv) n_mp++;
  endtask

  task automatic check_out(input string name);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: scoreboard empty, got rv=%b want an entry", name, redirect_valid);
    end else begin
      e = sb_q.pop_front();
      chk({name, ".rv"}, 32'(redirect_valid), 32'(e.rv));
      if (e.rv) chk({name, ".pc"}, redirect_pc, e.pc);
      chk({name, ".flush"}, 32'(flush), 32'(e.rv));
    end
  endtask

  task automatic flush_tail(input string name);
    for (int k = 1; k < int'(FLUSH_DEPTH); k++) begin
      step();
      chk({name, ".fl_hi"}, 32'(flush), 32'd1);
      chk({name, ".fl_rv"}, 32'(redirect_valid), 32'd0);
    end
    step();
    chk({name, ".fl_end"}, 32'(flush), 32'd0);
    chk({name, ".fl_rv_end"}, 32'(redirect_valid), 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    drive(v);
    step();
    idle();
    check_out(name);
    if (v.exp_rv) flush_tail(name);
  endtask

  vec_t tbl[11];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(1,0,0, 32'h200, 32'hFFFF_FFF8, 0, 1, 0, 0, 1, 32'h1F8);
    tbl[1]  = mk(0,0,1, 32'h40, 32'd4, 32'h1003, 0, 1, 32'h1006, 0, 0);
    tbl[2]  = mk(0,0,1, 32'h40, 32'd4, 32'h1003, 0, 1, 32'h1000, 1, 32'h1006);
    tbl[3]  = mk(1,0,0, 32'hFFFF_FFFC, 32'h10, 0, 0, 1, 32'hC, 1, 32'h0);
    tbl[4]  = mk(0,1,0, 32'h300, 32'h100, 0, 0, 0, 0, 1, 32'h400);
    tbl[5]  = mk(0,1,0, 32'h300, 32'h100, 0, 0, 1, 32'h400, 0, 0);
    tbl[6]  = mk(1,0,0, 32'h500, 32'h20, 0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(1,0,0, 32'h600, 32'h20, 0, 1, 1, 32'h640, 1, 32'h620);
    tbl[8]  = mk(0,0,1, 32'h44, 32'd3, 32'hFFFF_FFFF, 0, 0, 0, 1, 32'h2);
    tbl[9]  = mk(1,0,0, 32'h700, 32'h40, 0, 0, 1, 32'h740, 1, 32'h704);
    tbl[10] = mk(0,1,1, 32'h800, 32'h10, 32'h2000, 0, 1, 32'h810, 1, 32'h2010);

    idle();
    ex_pc = 0; ex_imm = 0; ex_rs1 = 0; branch_result = 0;
    ex_pred_taken = 0; ex_pred_target = 0;
    if_pc = 32'h100;
    rst_n = 1'b0;
    #12;
    chk("rst.rv", 32'(redirect_valid), 32'd0);
    chk("rst.pc", redirect_pc, 32'd0);
    chk("rst.flush", 32'(flush), 32'd0);
    chk("rst.pbr", perf_branches, 32'd0);
    chk("rst.pmp", perf_mispred, 32'd0);
    chk("rst.pred", 32'(if_pred_taken), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // BHT walk at 0x100: 01 -> 10 -> 11 -> 11, then back down.
    drive(mk(1,0,0, 32'h100, 32'h40, 0, 1, 1, 32'h140, 0, 0));
    #1;
    chk("t1.bypass", 32'(if_pred_taken), 32'd0);
    step();
    idle();
    check_out("t1.a");
    chk("t1.pred_a", 32'(if_pred_taken), 32'd1);
    for (int k = 0; k < 2; k++) begin
      run_vec(mk(1,0,0, 32'h100, 32'h40, 0, 1, 1, 32'h140, 0, 0), "t1.b");
      chk("t1.pred_b", 32'(if_pred_taken), 32'd1);
    end
    run_vec(mk(1,0,0, 32'h100, 32'h40, 0, 0, 1, 32'h140, 1, 32'h104), "t1.c");
    chk("t1.pred_c", 32'(if_pred_taken), 32'd1);
    run_vec(mk(1,0,0, 32'h100, 32'h40, 0, 0, 0, 0, 0, 0), "t1.d");
    chk("t1.pred_d", 32'(if_pred_taken), 32'd0);

    for (int i = 0; i < 11; i++)
      run_vec(tbl[i], $sformatf("vec%0d", i));
    chk("tbl.pbr", perf_branches, 32'(n_br));
    chk("tbl.pmp", perf_mispred, 32'(n_mp));

    // Wrong-path branch during FLUSH must be ignored.
    if_pc = 32'h10;
    drive(mk(1,0,0, 32'h200, 32'hFFFF_FFF8, 0, 1, 0, 0, 1, 32'h1F8));
    step();
    check_out("t4a");
    set_inputs(mk(1,0,0, 32'h10, 32'h8, 0, 1, 0, 0, 0, 0));
    step();
    chk("t4a.rv1", 32'(redirect_valid), 32'd0);
    chk("t4a.fl1", 32'(flush), 32'd1);
    step();
    idle();
    chk("t4a.rv2", 32'(redirect_valid), 32'd0);
    chk("t4a.fl2", 32'(flush), 32'd0);
    chk("t4a.pbr", perf_branches, 32'(n_br));
    chk("t4a.pmp", perf_mispred, 32'(n_mp));
    chk("t4a.pred", 32'(if_pred_taken), 32'd0);

    // Stalled mispredict holds everything until the stall drops.
    if_pc = 32'h20;
    set_inputs(mk(1,0,0, 32'h20, 32'h8, 0, 1, 0, 0, 0, 0));
    ex_stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("t4b.rv", 32'(redirect_valid), 32'd0);
      chk("t4b.fl", 32'(flush), 32'd0);
      chk("t4b.pbr", perf_branches, 32'(n_br));
      chk("t4b.pred", 32'(if_pred_taken), 32'd0);
    end
    run_vec(mk(1,0,0, 32'h20, 32'h8, 0, 1, 0, 0, 1, 32'h28), "t4b.go");
    chk("t4b.pred_go", 32'(if_pred_taken), 32'd1);
    chk("t4b.pmp", perf_mispred, 32'(n_mp));

    // Async reset in the first FLUSH cycle.
    drive(mk(1,0,0, 32'h200, 32'hFFFF_FFF8, 0, 1, 0, 0, 1, 32'h1F8));
    step();
    idle();
    check_out("t6");
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6.rv", 32'(redirect_valid), 32'd0);
    chk("t6.fl", 32'(flush), 32'd0);
    chk("t6.pc", redirect_pc, 32'd0);
    chk("t6.pbr", perf_branches, 32'd0);
    chk("t6.pmp", perf_mispred, 32'd0);
    chk("t6.pred20", 32'(if_pred_taken), 32'd0);
    if_pc = 32'h100;
    #1;
    chk("t6.pred100", 32'(if_pred_taken), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("t6.post_rv", 32'(redirect_valid), 32'd0);
      chk("t6.post_fl", 32'(flush), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
